alu_unit_mc: RTL and testbench

//  Multi-cycle, parametrised successor of the 64-bit combinational ALU unit: same ALUOp1/ALUOp0/funct7/funct3

---
 rtl/alu_unit_mc_if.sv | 30 +++
 rtl/alu_unit_mc.sv | 162 ++++++++++++++++
 tb/tb_alu_unit_mc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_unit_mc_if.sv
// Handshake and operand/result bundle for alu_unit_mc.
// master = operand source / result consumer, slave = the ALU.
interface alu_unit_mc_if #(
    parameter int unsigned N = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ALUOp1;
    logic         ALUOp0;
    logic [6:0]   funct7;
    logic [2:0]   funct3;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         zero;
    logic         illegal;
    logic         busy;

    modport master (
        output in_valid, A, B, ALUOp1, ALUOp0, funct7, funct3, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    modport slave (
        input  in_valid, A, B, ALUOp1, ALUOp0, funct7, funct3, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );
endinterface

// File: rtl/alu_unit_mc.sv
// Multi-cycle EX-stage ALU: RV-style ALUOp/funct decode, shifts, optional shift-add multiplier.
// Define ALU_MUL_EN to build the MUL state and datapath; otherwise MUL encodings decode illegal.
module alu_unit_mc #(
    parameter int unsigned N   = 64,
    parameter int unsigned BPC = 1
) (
    input logic          clk,
    input logic          rst,
    alu_unit_mc_if.slave bus
);
    localparam int unsigned LW = $clog2(N);

    if (N < 8 || (N & (N - 1)) != 0 || !(BPC == 1 || BPC == 2 || BPC == 4) || (N % BPC) != 0)
    begin : g_cfg_check
        $error("alu_unit_mc: unsupported N/BPC combination");
    end

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DONE
`ifdef ALU_MUL_EN
        , ST_MUL
`endif
    } state_e;

    state_e       state;
    op_e          op_c;
    logic [N-1:0] res_c;
    logic [LW-1:0] shamt_c;

    // Decode; funct fields are only looked at for R-type so X there cannot leak into ADD/SUB.
    always_comb begin
        op_c = OP_ILL;
        if (!bus.ALUOp1) begin
            op_c = bus.ALUOp0 ? OP_SUB : OP_ADD;
        end else if (bus.funct7 == 7'b0000001 && bus.funct3 == 3'b000) begin
`ifdef ALU_MUL_EN
            op_c = OP_MUL;
`else
            op_c = OP_ILL;
`endif
        end else begin
            case (bus.funct3)
                3'b000:  op_c = bus.funct7[5] ? OP_SUB : OP_ADD;
                3'b111:  op_c = OP_AND;
                3'b110:  op_c = OP_OR;
                3'b100:  op_c = OP_XOR;
                3'b001:  op_c = OP_SLL;
                3'b101:  op_c = bus.funct7[5] ? OP_SRA : OP_SRL;
                default: op_c = OP_ILL;
            endcase
        end
    end

    // Single-cycle datapath, evaluated on the accept cycle.
    always_comb begin
        shamt_c = bus.B[LW-1:0];
        case (op_c)
            OP_ADD:  res_c = bus.A + bus.B;
            OP_SUB:  res_c = bus.A - bus.B;
            OP_AND:  res_c = bus.A & bus.B;
            OP_OR:   res_c = bus.A | bus.B;
            OP_XOR:  res_c = bus.A ^ bus.B;
            OP_SLL:  res_c = bus.A << shamt_c;
            OP_SRL:  res_c = bus.A >> shamt_c;
            OP_SRA:  res_c = N'($signed(bus.A) >>> shamt_c);
            default: res_c = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int unsigned STEPS = N / BPC;
    localparam int unsigned CW    = $clog2(STEPS);

    logic [N-1:0]  mcand;
    logic [N-1:0]  mplier;
    logic [N-1:0]  acc;
    logic [N-1:0]  acc_next;
    logic [CW-1:0] count;

    // Retire BPC multiplier LSBs per step; bits above N are dropped.
    always_comb begin
        acc_next = acc;
        for (int unsigned j = 0; j < BPC; j++) begin
            if (mplier[j]) acc_next = acc_next + (mcand << j);
        end
    end
`else
    assign bus.busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            bus.busy      <= 1'b0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            count         <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
`ifdef ALU_MUL_EN
                        if (op_c == OP_MUL) begin
                            state    <= ST_MUL;
                            bus.busy <= 1'b1;
                            mcand    <= bus.A;
                            mplier   <= bus.B;
                            acc      <= '0;
                            count    <= '0;
                        end else
`endif
                        begin
                            state         <= ST_DONE;
                            bus.out_valid <= 1'b1;
                            bus.result    <= res_c;
                            bus.zero      <= (res_c == '0);
                            bus.illegal   <= (op_c == OP_ILL);
                        end
                    end
                end
`ifdef ALU_MUL_EN
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << BPC;
                    mplier <= mplier >> BPC;
                    count  <= count + CW'(1);
                    if (count == CW'(STEPS - 1)) begin
                        state         <= ST_DONE;
                        bus.busy      <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.result    <= acc_next;
                        bus.zero      <= (acc_next == '0);
                        bus.illegal   <= 1'b0;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state         <= ST_IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_unit_mc.sv
// Directed + random bench for alu_unit_mc against an arithmetic reference model.
module tb_alu_unit_mc;
    localparam int unsigned N   = 64;
    localparam int unsigned BPC = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_unit_mc_if #(.N(N)) bus ();

    alu_unit_mc #(.N(N), .BPC(BPC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: result, illegal flag and accept-to-out_valid latency from the decode table.
    function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                  input logic o1, input logic o0,
                                  input logic [6:0] f7, input logic [2:0] f3,
                                  output logic [N-1:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b % N);
        r   = '0;
        ill = 1'b0;
        lat = 1;
        if (!o1 && !o0)      r = a + b;
        else if (!o1 && o0)  r = a - b;
        else if (f7 == 7'd1 && f3 == 3'd0) begin
`ifdef ALU_MUL_EN
            r   = a * b;
            lat = N / BPC + 1;
`else
            ill = 1'b1;
`endif
        end else begin
            case (f3)
                3'd0: r = f7[5] ? a - b : a + b;
                3'd7: r = a & b;
                3'd6: r = a | b;
                3'd4: r = a ^ b;
                3'd1: r = a << sh;
                3'd5: begin
                    if (f7[5] && a[N-1]) r = ~((~a) >> sh);
                    else                 r = a >> sh;
                end
                default: ill = 1'b1;
            endcase
        end
    endfunction

    // One complete transaction with out_ready held high; called at a negedge.
    task automatic do_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic o1, input logic o0, input logic [6:0] f7, input logic [2:0] f3,
                         output logic [N-1:0] got);
        logic [N-1:0] er;
        logic         ei;
        int           elat;
        int           lat;
        int           bcnt;
        model(a, b, o1, o0, f7, f3, er, ei, elat);
        chk({tag, ".in_ready"}, N'(bus.in_ready), N'(1));
        bus.A      = a;
        bus.B      = b;
        bus.ALUOp1 = o1;
        bus.ALUOp0 = o0;
        if (o1) begin
            bus.funct7 = f7;
            bus.funct3 = f3;
        end else begin
            bus.funct7 = 'x;
            bus.funct3 = 'x;
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = N'({$urandom, $urandom});
        bus.B        = N'({$urandom, $urandom});
        bus.funct7   = 7'($urandom);
        bus.funct3   = 3'($urandom);
        lat  = 1;
        bcnt = 0;
        while (bus.out_valid !== 1'b1 && lat < 300) begin
            if (bus.busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
        got = bus.result;
        chk({tag, ".latency"}, N'(lat), N'(elat));
        chk({tag, ".busy_cycles"}, N'(bcnt), N'(elat - 1));
        chk({tag, ".result"}, bus.result, er);
        chk({tag, ".zero"}, N'(bus.zero), N'(er == '0));
        chk({tag, ".illegal"}, N'(bus.illegal), N'(ei));
        @(negedge clk);
        chk({tag, ".out_valid_drop"}, N'(bus.out_valid), N'(0));
        chk({tag, ".in_ready_back"}, N'(bus.in_ready), N'(1));
    endtask

    initial begin
        logic [N-1:0] got;
        logic [N-1:0] er;
        logic         ei;
        int           elat;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.A         = '0;
        bus.B         = '0;
        bus.ALUOp1    = 1'b0;
        bus.ALUOp0    = 1'b0;
        bus.funct7    = '0;
        bus.funct3    = '0;
        repeat (2) @(negedge clk);
        chk("rst.in_ready", N'(bus.in_ready), N'(1));
        chk("rst.out_valid", N'(bus.out_valid), N'(0));
        chk("rst.result", bus.result, '0);
        chk("rst.zero", N'(bus.zero), N'(0));
        chk("rst.illegal", N'(bus.illegal), N'(0));
        chk("rst.busy", N'(bus.busy), N'(0));
        rst = 1'b0;
        @(negedge clk);

        do_op("add", 64'd123, 64'd321, 1'b0, 1'b0, 7'd0, 3'd0, got);
        chk("add.const", got, 64'd444);
        do_op("beq", 64'd123, 64'd123, 1'b0, 1'b1, 7'd0, 3'd0, got);
        chk("beq.const", got, 64'd0);
        do_op("sub", 64'h8000000000000000, 64'd10, 1'b0, 1'b1, 7'd0, 3'd0, got);
        chk("sub.const", got, 64'h7FFFFFFFFFFFFFF6);
        do_op("addwrap", 64'h7FFFFFFFFFFFFFFF, 64'd1, 1'b1, 1'b0, 7'h00, 3'd0, got);
        chk("addwrap.const", got, 64'h8000000000000000);
        do_op("sra", 64'h8000000000000000, 64'd68, 1'b1, 1'b0, 7'h20, 3'd5, got);
        chk("sra.const", got, 64'hF800000000000000);
        do_op("srl", 64'h8000000000000000, 64'd68, 1'b1, 1'b0, 7'h00, 3'd5, got);
        chk("srl.const", got, 64'h0800000000000000);
        do_op("sll", 64'h1, 64'd63, 1'b1, 1'b0, 7'h00, 3'd1, got);
        chk("sll.const", got, 64'h8000000000000000);
        do_op("ill", 64'd5, 64'd6, 1'b1, 1'b1, 7'h00, 3'd2, got);
        do_op("mul", 64'd12345678, 64'd87654321, 1'b1, 1'b0, 7'h01, 3'd0, got);
`ifdef ALU_MUL_EN
        chk("mul.const", got, 64'd1082152022374638);
`else
        chk("mul.const", got, 64'd0);
`endif
        do_op("mulneg", '1, '1, 1'b1, 1'b0, 7'h01, 3'd0, got);
`ifdef ALU_MUL_EN
        chk("mulneg.const", got, 64'd1);
`else
        chk("mulneg.const", got, 64'd0);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic [6:0]   f7;
            int           sel;
            ra  = N'({$urandom, $urandom});
            rb  = ($urandom_range(0, 3) == 0) ? ra : N'({$urandom, $urandom});
            sel = int'($urandom_range(0, 3));
            f7  = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : (sel == 2) ? 7'h01 : 7'($urandom);
            do_op($sformatf("rnd%0d", i), ra, rb, 1'($urandom), 1'($urandom), f7, 3'($urandom), got);
        end

        // Backpressure: result held, second request ignored while DONE.
        model(64'hF0F0_1234_5678_9ABC, 64'h0FF0_FFFF_0000_FFFF, 1'b1, 1'b0, 7'h00, 3'd7, er, ei, elat);
        bus.A = 64'hF0F0_1234_5678_9ABC; bus.B = 64'h0FF0_FFFF_0000_FFFF;
        bus.ALUOp1 = 1'b1; bus.ALUOp0 = 1'b0; bus.funct7 = 7'h00; bus.funct3 = 3'd7;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.A = 64'd1; bus.B = 64'd2; bus.funct3 = 3'd0;
        chk("bp.out_valid", N'(bus.out_valid), N'(1));
        chk("bp.result", bus.result, er);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp.hold_result%0d", k), bus.result, er);
            chk($sformatf("bp.hold_zero%0d", k), N'(bus.zero), N'(er == '0));
            chk($sformatf("bp.hold_valid%0d", k), N'(bus.out_valid), N'(1));
            chk($sformatf("bp.in_ready%0d", k), N'(bus.in_ready), N'(0));
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp.drop", N'(bus.out_valid), N'(0));
        chk("bp.ready", N'(bus.in_ready), N'(1));
        @(negedge clk);
        chk("bp.no_phantom", N'(bus.out_valid), N'(0));

        // Reset ten cycles after accepting a MUL encoding (mid-MUL, or in DONE without the multiplier).
        bus.A = 64'd999; bus.B = 64'd777;
        bus.ALUOp1 = 1'b1; bus.ALUOp0 = 1'b0; bus.funct7 = 7'h01; bus.funct3 = 3'd0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
`ifdef ALU_MUL_EN
        chk("rstmid.busy_before", N'(bus.busy), N'(1));
`else
        chk("rstmid.valid_before", N'(bus.out_valid), N'(1));
`endif
        rst = 1'b1;
        #1;
        chk("rstmid.out_valid", N'(bus.out_valid), N'(0));
        chk("rstmid.busy", N'(bus.busy), N'(0));
        chk("rstmid.result", bus.result, '0);
        chk("rstmid.illegal", N'(bus.illegal), N'(0));
        chk("rstmid.in_ready", N'(bus.in_ready), N'(1));
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        do_op("post_rst_add", 64'd40, 64'd2, 1'b0, 1'b0, 7'd0, 3'd0, got);
        chk("post_rst_add.const", got, 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
